// File: rtl/seq_mult_sched_pkg.sv
// rtl/seq_mult_sched_pkg.sv - shared types, default widths and config checks for seq_mult_sched
package seq_mult_sched_pkg;

    localparam int SCHED_K         = 2;
    localparam int SCHED_MAX_WIDTH = 16;
    localparam int SCHED_P         = 2;
    localparam int SCHED_DIM_W     = 8;
    localparam int SCHED_ADDR_W    = 16;
    localparam int SCHED_BS_W      = $clog2(SCHED_MAX_WIDTH / SCHED_P) + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_WRITE
    } sched_state_e;

    // A bitsize counts P-bit datapath steps; zero steps or more than the operand holds is unusable.
    function automatic logic bitsize_ok(input int bitsize, input int max_steps);
        return (bitsize != 0) && (bitsize <= max_steps);
    endfunction

endpackage

// File: rtl/seq_mult_sched_if.sv
// rtl/seq_mult_sched_if.sv - datapath job/response and result stream bundle for seq_mult_sched
interface seq_mult_sched_if
    import seq_mult_sched_pkg::*;
#(
    parameter int K         = SCHED_K,
    parameter int MAX_WIDTH = SCHED_MAX_WIDTH,
    parameter int DIM_W     = SCHED_DIM_W,
    parameter int BS_W      = SCHED_BS_W
) ();

    logic                   dp_valid_o;
    logic                   dp_ready_i;
    logic [K*MAX_WIDTH-1:0] dp_row_o;
    logic [K*MAX_WIDTH-1:0] dp_col_o;
    logic [31:0]            dp_cin_o;
    logic [BS_W-1:0]        dp_bitsize_o;

    logic                   dp_valid_i;
    logic                   dp_ready_o;
    logic [31:0]            dp_result_i;

    logic                   res_valid_o;
    logic                   res_ready_i;
    logic [31:0]            res_data_o;
    logic [DIM_W-1:0]       res_m_o;
    logic [DIM_W-1:0]       res_n_o;

    modport master (
        output dp_valid_o, dp_row_o, dp_col_o, dp_cin_o, dp_bitsize_o,
        input  dp_ready_i,
        input  dp_valid_i, dp_result_i,
        output dp_ready_o,
        output res_valid_o, res_data_o, res_m_o, res_n_o,
        input  res_ready_i
    );

    modport slave (
        input  dp_valid_o, dp_row_o, dp_col_o, dp_cin_o, dp_bitsize_o,
        output dp_ready_i,
        output dp_valid_i, dp_result_i,
        input  dp_ready_o,
        input  res_valid_o, res_data_o, res_m_o, res_n_o,
        output res_ready_i
    );

endinterface

// File: rtl/seq_mult_sched_loop_counter.sv
// rtl/seq_mult_sched_loop_counter.sv - k/n/m loop counters and chunk address generation
module sched_loop_counter
    import seq_mult_sched_pkg::*;
#(
    parameter int DIM_W  = SCHED_DIM_W,
    parameter int ADDR_W = SCHED_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              adv_k_i,
    input  logic              adv_n_i,
    input  logic [DIM_W-1:0]  cfg_m_i,
    input  logic [DIM_W-1:0]  cfg_n_i,
    input  logic [DIM_W-1:0]  cfg_kt_i,
    output logic [DIM_W-1:0]  n_o,
    output logic [DIM_W-1:0]  m_o,
    output logic [ADDR_W-1:0] a_addr_o,
    output logic [ADDR_W-1:0] b_addr_o,
    output logic              k_last_o,
    output logic              n_last_o,
    output logic              m_last_o
);

    logic [DIM_W-1:0]  k_q, k_d;
    logic [DIM_W-1:0]  n_q, n_d;
    logic [DIM_W-1:0]  m_q, m_d;
    logic [ADDR_W-1:0] a_base_q, a_base_d;
    logic [ADDR_W-1:0] b_base_q, b_base_d;
    logic [ADDR_W-1:0] kt_step;

    assign kt_step  = ADDR_W'(cfg_kt_i);
    assign k_last_o = (k_q == cfg_kt_i - DIM_W'(1));
    assign n_last_o = (n_q == cfg_n_i - DIM_W'(1));
    assign m_last_o = (m_q == cfg_m_i - DIM_W'(1));
    assign n_o      = n_q;
    assign m_o      = m_q;

    // Bases step by KT per row/column, so m*KT and n*KT never need a multiplier.
    assign a_addr_o = a_base_q + ADDR_W'(k_q);
    assign b_addr_o = b_base_q + ADDR_W'(k_q);

    always_comb begin
        k_d      = k_q;
        n_d      = n_q;
        m_d      = m_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        if (clear_i) begin
            k_d      = '0;
            n_d      = '0;
            m_d      = '0;
            a_base_d = '0;
            b_base_d = '0;
        end else if (adv_n_i) begin
            k_d = '0;
            if (n_last_o) begin
                n_d      = '0;
                b_base_d = '0;
                m_d      = m_q + DIM_W'(1);
                a_base_d = a_base_q + kt_step;
            end else begin
                n_d      = n_q + DIM_W'(1);
                b_base_d = b_base_q + kt_step;
            end
        end else if (adv_k_i) begin
            k_d = k_q + DIM_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            k_q      <= '0;
            n_q      <= '0;
            m_q      <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
        end else begin
            k_q      <= k_d;
            n_q      <= n_d;
            m_q      <= m_d;
            a_base_q <= a_base_d;
            b_base_q <= b_base_d;
        end
    end

endmodule

// File: rtl/seq_mult_sched.sv
// rtl/seq_mult_sched.sv - tiled matrix-product sequencer for one seq_mult_adder datapath (option: SEQ_MULT_SCHED_PERF_EN)
module seq_mult_sched
    import seq_mult_sched_pkg::*;
#(
    parameter int K         = SCHED_K,
    parameter int MAX_WIDTH = SCHED_MAX_WIDTH,
    parameter int P         = SCHED_P,
    parameter int DIM_W     = SCHED_DIM_W,
    parameter int ADDR_W    = SCHED_ADDR_W,
    parameter int BS_W      = $clog2(MAX_WIDTH / P) + 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [DIM_W-1:0]       cfg_m_i,
    input  logic [DIM_W-1:0]       cfg_n_i,
    input  logic [DIM_W-1:0]       cfg_kt_i,
    input  logic [BS_W-1:0]        cfg_bitsize_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic                   mem_req_o,
    output logic [ADDR_W-1:0]      a_addr_o,
    output logic [ADDR_W-1:0]      b_addr_o,
    input  logic [K*MAX_WIDTH-1:0] a_data_i,
    input  logic [K*MAX_WIDTH-1:0] b_data_i,
    seq_mult_sched_if.master       bus
`ifdef SEQ_MULT_SCHED_PERF_EN
    ,
    output logic [31:0]            perf_cycles_o,
    output logic [31:0]            perf_stall_o
`endif
);

    localparam int MAX_STEPS = MAX_WIDTH / P;

    sched_state_e           state_q, state_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   mem_req_q, mem_req_d;
    logic                   dp_valid_q, dp_valid_d;
    logic                   dp_ready_q, dp_ready_d;
    logic                   res_valid_q, res_valid_d;
    logic [DIM_W-1:0]       cfg_m_q, cfg_m_d;
    logic [DIM_W-1:0]       cfg_n_q, cfg_n_d;
    logic [DIM_W-1:0]       cfg_kt_q, cfg_kt_d;
    logic [BS_W-1:0]        bitsize_q, bitsize_d;
    logic [K*MAX_WIDTH-1:0] row_q, row_d;
    logic [K*MAX_WIDTH-1:0] col_q, col_d;
    logic [31:0]            cin_q, cin_d;
    logic [31:0]            res_data_q, res_data_d;

    logic                   clear, adv_k, adv_n;
    logic                   k_last, n_last, m_last;
    logic [DIM_W-1:0]       n_cnt, m_cnt;
    logic                   cfg_zero, cfg_bad, accept;

    assign cfg_zero = (cfg_m_i == '0) || (cfg_n_i == '0) || (cfg_kt_i == '0);
    assign cfg_bad  = !bitsize_ok(int'(cfg_bitsize_i), MAX_STEPS);
    assign accept   = (state_q == S_IDLE) && start_i && !cfg_zero && !cfg_bad;

    sched_loop_counter #(
        .DIM_W  (DIM_W),
        .ADDR_W (ADDR_W)
    ) u_loop (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (clear),
        .adv_k_i  (adv_k),
        .adv_n_i  (adv_n),
        .cfg_m_i  (cfg_m_q),
        .cfg_n_i  (cfg_n_q),
        .cfg_kt_i (cfg_kt_q),
        .n_o      (n_cnt),
        .m_o      (m_cnt),
        .a_addr_o (a_addr_o),
        .b_addr_o (b_addr_o),
        .k_last_o (k_last),
        .n_last_o (n_last),
        .m_last_o (m_last)
    );

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        cfg_m_d    = cfg_m_q;
        cfg_n_d    = cfg_n_q;
        cfg_kt_d   = cfg_kt_q;
        bitsize_d  = bitsize_q;
        row_d      = row_q;
        col_d      = col_q;
        cin_d      = cin_q;
        res_data_d = res_data_q;
        clear      = 1'b0;
        adv_k      = 1'b0;
        adv_n      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (cfg_zero) begin
                        done_d = 1'b1;
                    end else if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        cfg_m_d   = cfg_m_i;
                        cfg_n_d   = cfg_n_i;
                        cfg_kt_d  = cfg_kt_i;
                        bitsize_d = cfg_bitsize_i;
                        cin_d     = '0;
                        clear     = 1'b1;
                        busy_d    = 1'b1;
                        state_d   = S_FETCH;
                    end
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                row_d   = a_data_i;
                col_d   = b_data_i;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (bus.dp_ready_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.dp_valid_i) begin
                    if (!k_last) begin
                        cin_d   = bus.dp_result_i;
                        adv_k   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        res_data_d = bus.dp_result_i;
                        state_d    = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (bus.res_ready_i) begin
                    cin_d = '0;
                    if (m_last && n_last) begin
                        clear   = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        adv_n   = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Strobes are registered from the next state so they line up with state_q.
        mem_req_d   = (state_d == S_FETCH);
        dp_valid_d  = (state_d == S_ISSUE);
        dp_ready_d  = (state_d == S_WAIT);
        res_valid_d = (state_d == S_WRITE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            dp_valid_q  <= 1'b0;
            dp_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            cfg_m_q     <= '0;
            cfg_n_q     <= '0;
            cfg_kt_q    <= '0;
            bitsize_q   <= '0;
            row_q       <= '0;
            col_q       <= '0;
            cin_q       <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            dp_valid_q  <= dp_valid_d;
            dp_ready_q  <= dp_ready_d;
            res_valid_q <= res_valid_d;
            cfg_m_q     <= cfg_m_d;
            cfg_n_q     <= cfg_n_d;
            cfg_kt_q    <= cfg_kt_d;
            bitsize_q   <= bitsize_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cin_q       <= cin_d;
            res_data_q  <= res_data_d;
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign mem_req_o        = mem_req_q;
    assign bus.dp_valid_o   = dp_valid_q;
    assign bus.dp_row_o     = row_q;
    assign bus.dp_col_o     = col_q;
    assign bus.dp_cin_o     = cin_q;
    assign bus.dp_bitsize_o = bitsize_q;
    assign bus.dp_ready_o   = dp_ready_q;
    assign bus.res_valid_o  = res_valid_q;
    assign bus.res_data_o   = res_data_q;
    assign bus.res_m_o      = m_cnt;
    assign bus.res_n_o      = n_cnt;

`ifdef SEQ_MULT_SCHED_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic        stall_now;

    assign stall_now = ((state_q == S_ISSUE) && !bus.dp_ready_i) ||
                       ((state_q == S_WRITE) && !bus.res_ready_i);

    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stall_d  = perf_stall_q;
        if (accept) begin
            perf_cycles_d = '0;
            perf_stall_d  = '0;
        end else begin
            if (busy_q && (perf_cycles_q != '1)) perf_cycles_d = perf_cycles_q + 32'd1;
            if (stall_now && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_cycles_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_cycles_o = perf_cycles_q;
    assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_seq_mult_sched.sv
// tb/tb_seq_mult_sched.sv - directed self-checking bench for seq_mult_sched
module tb_seq_mult_sched;
    import seq_mult_sched_pkg::*;

    localparam int KW = SCHED_K * SCHED_MAX_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [7:0]            cfg_m = '0, cfg_n = '0, cfg_kt = '0;
    logic [SCHED_BS_W-1:0] cfg_bs = '0;
    logic                  busy, done, err, mem_req;
    logic [15:0]           a_addr, b_addr;
    logic [KW-1:0]         a_data = '0, b_data = '0;
`ifdef SEQ_MULT_SCHED_PERF_EN
    logic [31:0]           perf_cycles, perf_stall;
`endif

    seq_mult_sched_if bus ();

    seq_mult_sched dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .cfg_m_i       (cfg_m),
        .cfg_n_i       (cfg_n),
        .cfg_kt_i      (cfg_kt),
        .cfg_bitsize_i (cfg_bs),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .mem_req_o     (mem_req),
        .a_addr_o      (a_addr),
        .b_addr_o      (b_addr),
        .a_data_i      (a_data),
        .b_data_i      (b_data),
        .bus           (bus)
`ifdef SEQ_MULT_SCHED_PERF_EN
        ,
        .perf_cycles_o (perf_cycles),
        .perf_stall_o  (perf_stall)
`endif
    );

    int checks = 0;
    int failures = 0;
    int mem_req_cnt = 0;
    int done_cnt = 0;
    int res_valid_cyc = 0;
    int base_req, base_done, base_res;
    logic [SCHED_BS_W-1:0] exp_bs;
    logic [15:0] a_log[$];
    logic [15:0] b_log[$];
    logic [15:0] a_exp[12] = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
    logic [15:0] b_exp[12] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_a(input logic [15:0] addr);
        return {16'h2000 + addr, 16'h1000 + addr};
    endfunction

    function automatic logic [31:0] mem_b(input logic [15:0] addr);
        return {16'h4000 + addr, 16'h3000 + addr};
    endfunction

    always @(posedge clk) begin
        if (mem_req) begin
            a_data <= mem_a(a_addr);
            b_data <= mem_b(b_addr);
        end
    end

    always @(negedge clk) begin
        if (mem_req) begin
            mem_req_cnt++;
            a_log.push_back(a_addr);
            b_log.push_back(b_addr);
        end
        if (done) done_cnt++;
        if (bus.res_valid_o) res_valid_cyc++;
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic probe(input int w);
        case (w)
            0:       return bus.dp_valid_o;
            1:       return bus.dp_ready_o;
            default: return bus.res_valid_o;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int w);
        int n = 0;
        while (!probe(w) && n < 40) begin
            cyc();
            n++;
        end
        chk({tag, "_timeout"}, 64'(n < 40), 64'd1);
    endtask

    task automatic launch(input int m, input int n, input int kt, input int bs);
        cfg_m  = 8'(m);
        cfg_n  = 8'(n);
        cfg_kt = 8'(kt);
        cfg_bs = SCHED_BS_W'(bs);
        exp_bs = SCHED_BS_W'(bs);
        start  = 1'b1;
        cyc();
        start  = 1'b0;
    endtask

    task automatic chunk(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                         input logic [31:0] ecin, input logic [31:0] result, input int stall);
        wait_for({tag, "_issue"}, 0);
        if (stall > 0) bus.dp_ready_i = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            chk({tag, "_valid"}, bus.dp_valid_o, 1);
            chk({tag, "_row"}, bus.dp_row_o, mem_a(ea));
            chk({tag, "_col"}, bus.dp_col_o, mem_b(eb));
            chk({tag, "_cin"}, bus.dp_cin_o, ecin);
            chk({tag, "_bs"}, bus.dp_bitsize_o, exp_bs);
            if (i < stall) cyc();
        end
        bus.dp_ready_i = 1'b1;
        wait_for({tag, "_wait"}, 1);
        bus.dp_valid_i  = 1'b1;
        bus.dp_result_i = result;
        cyc();
        bus.dp_valid_i  = 1'b0;
        bus.dp_result_i = '0;
    endtask

    task automatic element(input string tag, input int m, input int n,
                           input logic [31:0] eres, input int stall);
        wait_for({tag, "_write"}, 2);
        if (stall > 0) bus.res_ready_i = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            chk({tag, "_rvalid"}, bus.res_valid_o, 1);
            chk({tag, "_rdata"}, bus.res_data_o, eres);
            chk({tag, "_rm"}, bus.res_m_o, m);
            chk({tag, "_rn"}, bus.res_n_o, n);
            if (i < stall) cyc();
        end
        bus.res_ready_i = 1'b1;
        cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.dp_ready_i  = 1'b1;
        bus.dp_valid_i  = 1'b0;
        bus.dp_result_i = '0;
        bus.res_ready_i = 1'b1;
        exp_bs          = '0;
        repeat (2) cyc();

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_memreq", mem_req, 0);
        chk("rst_dpvalid", bus.dp_valid_o, 0);
        chk("rst_dpready", bus.dp_ready_o, 0);
        chk("rst_resvalid", bus.res_valid_o, 0);
        chk("rst_aaddr", a_addr, 0);
        chk("rst_cin", bus.dp_cin_o, 0);
        rst = 1'b0;
        cyc();

        // single element, single chunk
        base_req = mem_req_cnt; base_done = done_cnt;
        launch(1, 1, 1, 8);
        chk("t1_busy", busy, 1);
        chk("t1_memreq", mem_req, 1);
        chk("t1_aaddr", a_addr, 0);
        chk("t1_baddr", b_addr, 0);
        chunk("t1c0", 16'd0, 16'd0, 32'h0, 32'h15, 0);
        element("t1", 0, 0, 32'h15, 0);
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);
        cyc();
        chk("t1_done_pulse", done, 0);
        chk("t1_done_cnt", done_cnt - base_done, 1);
        chk("t1_req_cnt", mem_req_cnt - base_req, 1);

        // 2x2 with three chunks each: loop order and partial-sum chaining
        a_log.delete(); b_log.delete();
        launch(2, 2, 3, 4);
        for (int e = 0; e < 4; e++) begin
            for (int k = 0; k < 3; k++) begin
                chunk($sformatf("t2e%0dk%0d", e, k), 16'((e / 2) * 3 + k), 16'((e % 2) * 3 + k),
                      (k == 0) ? 32'h0 : 32'(32'h100 * (e + 1) + k - 1),
                      32'(32'h100 * (e + 1) + k), 0);
            end
            element($sformatf("t2e%0d", e), e / 2, e % 2, 32'(32'h100 * (e + 1) + 2), 0);
        end
        chk("t2_done", done, 1);
        chk("t2_nreq", a_log.size(), 12);
        for (int i = 0; i < 12 && i < a_log.size(); i++) begin
            chk($sformatf("t2_aaddr%0d", i), a_log[i], a_exp[i]);
            chk($sformatf("t2_baddr%0d", i), b_log[i], b_exp[i]);
        end
        cyc();

        // backpressure on the job and result handshakes
        base_req = mem_req_cnt;
        launch(1, 1, 2, 3);
        chunk("t3c0", 16'd0, 16'd0, 32'h0, 32'h33, 0);
        chunk("t3c1", 16'd1, 16'd1, 32'h33, 32'h77, 5);
        element("t3", 0, 0, 32'h77, 4);
        chk("t3_done", done, 1);
        chk("t3_req_cnt", mem_req_cnt - base_req, 2);
        cyc();

        // rejected bitsizes at both ends of the legal range
        launch(1, 1, 1, 0);
        chk("t4a_err", err, 1);
        chk("t4a_busy", busy, 0);
        chk("t4a_memreq", mem_req, 0);
        cyc();
        chk("t4a_err_pulse", err, 0);
        chk("t4a_busy2", busy, 0);
        launch(1, 1, 1, 9);
        chk("t4b_err", err, 1);
        chk("t4b_busy", busy, 0);
        cyc();

        // zero dimension finishes without work
        base_req = mem_req_cnt; base_res = res_valid_cyc;
        launch(2, 0, 2, 4);
        chk("t5_done", done, 1);
        chk("t5_busy", busy, 0);
        chk("t5_err", err, 0);
        repeat (5) cyc();
        chk("t5_req_cnt", mem_req_cnt - base_req, 0);
        chk("t5_res_cnt", res_valid_cyc - base_res, 0);

        // reset in the middle of a WAIT
        launch(2, 2, 3, 4);
        for (int k = 0; k < 3; k++) begin
            chunk($sformatf("t6k%0d", k), 16'(k), 16'(k), (k == 0) ? 32'h0 : 32'(32'h50 + k - 1),
                  32'(32'h50 + k), 0);
        end
        element("t6e0", 0, 0, 32'h52, 0);
        wait_for("t6_issue", 0);
        wait_for("t6_wait", 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_dpready", bus.dp_ready_o, 0);
        chk("t6_rst_dpvalid", bus.dp_valid_o, 0);
        chk("t6_rst_memreq", mem_req, 0);
        chk("t6_rst_resvalid", bus.res_valid_o, 0);
        chk("t6_rst_resdata", bus.res_data_o, 0);
        chk("t6_rst_row", bus.dp_row_o, 0);
        chk("t6_rst_cin", bus.dp_cin_o, 0);
        chk("t6_rst_baddr", b_addr, 0);
        chk("t6_rst_resn", bus.res_n_o, 0);
        cyc();
        rst = 1'b0;
        cyc();

        // fresh run; a second start while busy must be ignored
        base_req = mem_req_cnt; base_res = res_valid_cyc; base_done = done_cnt;
        launch(1, 1, 1, 2);
        cfg_m = 8'd2; cfg_n = 8'd2; cfg_kt = 8'd2; cfg_bs = SCHED_BS_W'(5);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chunk("t7c0", 16'd0, 16'd0, 32'h0, 32'h5A, 0);
        element("t7", 0, 0, 32'h5A, 0);
        chk("t7_done", done, 1);
        repeat (5) cyc();
        chk("t7_busy", busy, 0);
        chk("t7_req_cnt", mem_req_cnt - base_req, 1);
        chk("t7_res_cnt", res_valid_cyc - base_res, 1);
        chk("t7_done_cnt", done_cnt - base_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
